mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage MIPS core. Consumes the EX/MEM register outputs and resolves branches (pcSrc, branch target).
- Performs the load/store through a req/ack data-memory port. Stalls the pipeline while an access is outstanding.
- Registers results into the MEM/WB pipeline register that feeds the WB stage and the forwarding mux (resultW).

Parameters:
- DATA_W, 32, data/address width.
- TIMEOUT_CYCLES, 16, max ACCESS-state cycles before timeout abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low reset
- controlBits  input  5  [4]Branch [3]MemRead [2]MemWrite [1]RegWrite [0]MemtoReg
- addResult  input  32  branch target from EX
- zero  input  1  ALU zero flag from EX
- ulaResult  input  32  ALU result / memory address
- rData2  input  32  store data
- writeReg  input  5  destination register number
- pcSrc  output  1  take branch
- branchTarget  output  32  = addResult
- dmem_req  output  1  memory request
- dmem_we  output  1  1=write, 0=read
- dmem_addr  output  32  = ulaResult
- dmem_wdata  output  32  = rData2
- dmem_rdata  input  32  read data, valid when dmem_ack=1
- dmem_ack  input  1  access complete
- stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
- wbControl  output  2  registered {RegWrite, MemtoReg}
- memDataW  output  32  registered load data
- aluResultW  output  32  registered ulaResult
- writeRegW  output  5  registered writeReg
- mem_err  output  1  sticky timeout flag (0 without macro)

Behaviour:
- memOp = MemRead | MemWrite.
- Both MemRead and MemWrite set: treat as write; read data ignored.
- pcSrc = Branch & zero, combinational, independent of stall. branchTarget = addResult.
- FSM states: IDLE, ACCESS.
- IDLE:
  - memOp=1: dmem_req=1 combinationally.
  - dmem_ack=1 same cycle: complete with no stall, stay IDLE.
  - Else: stall=1, go to ACCESS.
- ACCESS:
  - dmem_req=1 is held; address, wdata and we stay stable because EX/MEM is frozen by stall.
  - stall=!dmem_ack.
  - On dmem_ack: complete and go to IDLE.
- stall = memOp & !dmem_ack in either state. dmem_req=0 whenever memOp=0.
- Completing a read captures dmem_rdata into memDataW at that clock edge.
- MEM/WB register loads on every clock edge where stall=0:
  - wbControl, aluResultW, writeRegW load from inputs.
  - memDataW loads only on a completing read; otherwise it holds its value.
- During stall, MEM/WB loads a bubble: wbControl=2'b00, other fields hold. This guarantees single writeback.
- Latency: non-memory instruction 1 cycle to MEM/WB. Load/store 1 + wait cycles.
- Reset (async, active-low, any time including mid-ACCESS):
  - FSM to IDLE.
  - Registered outputs cleared: wbControl=0, memDataW=0, aluResultW=0, writeRegW=0, mem_err=0.
  - dmem_req drops immediately unless memOp=1 on the reset-release cycle. It then restarts from IDLE.
- Back-to-back memory ops: a new request may be asserted in the cycle after the ack. No idle gap is required.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When count reaches TIMEOUT_CYCLES-1 with no ack, the access aborts: FSM to IDLE, stall=0 that cycle.
  - MEM/WB gets wbControl=2'b00; memDataW is unchanged. mem_err is set and stays set until reset.
  - An ack arriving in the abort cycle wins: normal completion, no error.
- Undefined:
  - No counter exists; ACCESS waits for ack indefinitely.
  - mem_err is tied to 0.

Decomposition:
- Shared package mips_pkg holds:
  - Control-bit index constants (CB_BRANCH=4, CB_MEMREAD=3, CB_MEMWRITE=2, CB_REGWRITE=1, CB_MEMTOREG=0).
  - State typedef mem_state_t {IDLE, ACCESS}.
- One sub-module, mem_wb: the MEM/WB pipeline register with load-enable and bubble insert.

Test Plan:
- Non-memory op: controlBits=5'b00010, ulaResult=0x1234, writeReg=7, no stall -> next edge wbControl=2'b10, aluResultW=0x1234, writeRegW=7, dmem_req=0.
- Load, ack after 3 cycles with rdata=0xCAFEF00D:
  - stall=1 for 3 cycles; wbControl=00 during the stall.
  - On the ack edge: memDataW=0xCAFEF00D, wbControl=2'b11.
- Store with ack in the same cycle: dmem_req=1, dmem_we=1, dmem_addr=ulaResult, dmem_wdata=rData2; stall never asserted; wbControl=00.
- Branch with zero=1, addResult=0x400 -> pcSrc=1, branchTarget=0x400. With zero=0 -> pcSrc=0.
- Reset pulled low 2 cycles into a pending load -> dmem_req=0 and all registered outputs 0 immediately; after release with memOp=0, FSM stays IDLE.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, load never acked -> abort after 16 ACCESS cycles; mem_err=1 sticky; stall=0; wbControl=00; memDataW unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: control-bit positions in the EX/MEM
// control bundle and the MEM stage access-state encoding.
package mips_pkg;

  localparam int CB_BRANCH   = 4;
  localparam int CB_MEMREAD  = 3;
  localparam int CB_MEMWRITE = 2;
  localparam int CB_REGWRITE = 1;
  localparam int CB_MEMTOREG = 0;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: load-enable plus bubble insert.
// Ports: load/readDone controls, WB-bound fields in and out.
module mem_wb
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              readDone,
  input  logic [1:0]        wbCtrlIn,
  input  logic [DATA_W-1:0] memDataIn,
  input  logic [DATA_W-1:0] aluIn,
  input  logic [4:0]        writeRegIn,
  output logic [1:0]        wbControl,
  output logic [DATA_W-1:0] memDataW,
  output logic [DATA_W-1:0] aluResultW,
  output logic [4:0]        writeRegW
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbControl  <= 2'b00;
      memDataW   <= '0;
      aluResultW <= '0;
      writeRegW  <= '0;
    end else if (load) begin
      wbControl  <= wbCtrlIn;
      aluResultW <= aluIn;
      writeRegW  <= writeRegIn;
      if (readDone)
        memDataW <= memDataIn;
    end else begin
      // bubble: no writeback, data fields hold
      wbControl <= 2'b00;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolve, req/ack data access, MEM/WB reg.
// Ports: EX/MEM inputs, dmem port, stall, MEM/WB outputs, mem_err.
// Optional MEM_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        controlBits,
  input  logic [DATA_W-1:0] addResult,
  input  logic              zero,
  input  logic [DATA_W-1:0] ulaResult,
  input  logic [DATA_W-1:0] rData2,
  input  logic [4:0]        writeReg,
  output logic              pcSrc,
  output logic [DATA_W-1:0] branchTarget,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic [1:0]        wbControl,
  output logic [DATA_W-1:0] memDataW,
  output logic [DATA_W-1:0] aluResultW,
  output logic [4:0]        writeRegW,
  output logic              mem_err
);

  mem_state_t state;
  logic memOp;
  logic active;
  logic isWrite;
  logic abort;
  logic readDone;

  assign memOp   = controlBits[CB_MEMREAD]
                 | controlBits[CB_MEMWRITE];
  assign isWrite = controlBits[CB_MEMWRITE];
  // no request leaves the stage while held in reset
  assign active  = memOp & reset;

  assign pcSrc        = controlBits[CB_BRANCH] & zero;
  assign branchTarget = addResult;

  assign dmem_req   = active;
  assign dmem_we    = isWrite;
  assign dmem_addr  = ulaResult;
  assign dmem_wdata = rData2;

  assign stall    = active & ~dmem_ack & ~abort;
  // read+write together behaves as a write
  assign readDone = active & dmem_ack & ~isWrite;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmoCnt;
  logic          errQ;

  // an ack in the final cycle wins over the abort
  assign abort = (state == ACCESS) & active & ~dmem_ack
               & (tmoCnt == CW'(TIMEOUT_CYCLES - 1));
  assign mem_err = errQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      tmoCnt <= '0;
      errQ   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (active & ~dmem_ack) begin
            state  <= ACCESS;
            tmoCnt <= '0;
          end
        end
        ACCESS: begin
          if (dmem_ack | ~memOp) begin
            state <= IDLE;
          end else if (abort) begin
            state <= IDLE;
            errQ  <= 1'b1;
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign abort   = 1'b0 & (TIMEOUT_CYCLES == 0);
  assign mem_err = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (active & ~dmem_ack)
            state <= ACCESS;
        ACCESS:
          if (dmem_ack | ~memOp)
            state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

  mem_wb #(
    .DATA_W(DATA_W)
  ) u_mem_wb (
    .clk       (clk),
    .reset     (reset),
    .load      (~stall & ~abort),
    .readDone  (readDone),
    .wbCtrlIn  ({controlBits[CB_REGWRITE],
                 controlBits[CB_MEMTOREG]}),
    .memDataIn (dmem_rdata),
    .aluIn     (ulaResult),
    .writeRegIn(writeReg),
    .wbControl (wbControl),
    .memDataW  (memDataW),
    .aluResultW(aluResultW),
    .writeRegW (writeRegW)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of MEM/WB results
// popped by a monitor, plus directed checks of the dmem port.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  controlBits;
  logic [31:0] addResult;
  logic        zero;
  logic [31:0] ulaResult;
  logic [31:0] rData2;
  logic [4:0]  writeReg;
  logic        pcSrc;
  logic [31:0] branchTarget;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic [1:0]  wbControl;
  logic [31:0] memDataW;
  logic [31:0] aluResultW;
  logic [4:0]  writeRegW;
  logic        mem_err;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] md;
    logic [31:0] alu;
    logic [4:0]  wr;
  } exp_t;

  exp_t sbQ[$];
  int   nCmp = 0;
  int   nErr = 0;
  logic wasStall;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk         (clk),
    .reset       (reset),
    .controlBits (controlBits),
    .addResult   (addResult),
    .zero        (zero),
    .ulaResult   (ulaResult),
    .rData2      (rData2),
    .writeReg    (writeReg),
    .pcSrc       (pcSrc),
    .branchTarget(branchTarget),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .stall       (stall),
    .wbControl   (wbControl),
    .memDataW    (memDataW),
    .aluResultW  (aluResultW),
    .writeRegW   (writeRegW),
    .mem_err     (mem_err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: a stalled edge must load a bubble; an unstalled edge
  // retires the oldest issued instruction into MEM/WB.
  always @(posedge clk) begin
    if (reset) begin
      wasStall = stall;
      #1;
      if (wasStall) begin
        chk("bubble_wb", 32'(wbControl), 32'd0);
      end else if (sbQ.size() > 0) begin
        exp_t e;
        e = sbQ.pop_front();
        chk("wbControl", 32'(wbControl), 32'(e.wb));
        chk("memDataW", memDataW, e.md);
        chk("aluResultW", aluResultW, e.alu);
        chk("writeRegW", 32'(writeRegW), 32'(e.wr));
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    controlBits = 5'b0;
    dmem_ack    = 1'b0;
    zero        = 1'b0;
  endtask

  task automatic issue(input logic [4:0]  cb,
                       input logic [31:0] addR,
                       input logic        z,
                       input logic [31:0] ula,
                       input logic [31:0] rd2,
                       input logic [4:0]  wr,
                       input int          ackAfter,
                       input logic [31:0] rdata,
                       input logic        expPc,
                       input exp_t        e);
    logic mo;
    mo = cb[3] | cb[2];
    @(negedge clk);
    controlBits = cb;
    addResult   = addR;
    zero        = z;
    ulaResult   = ula;
    rData2      = rd2;
    writeReg    = wr;
    dmem_rdata  = rdata;
    sbQ.push_back(e);
    for (int i = 0; i <= ackAfter; i++) begin
      if (i > 0) @(negedge clk);
      dmem_ack = mo && (i == ackAfter);
      #1;
      chk("stall", 32'(stall), 32'(mo && i < ackAfter));
      chk("dmem_req", 32'(dmem_req), 32'(mo));
      if (i == 0) begin
        chk("pcSrc", 32'(pcSrc), 32'(expPc));
        chk("branchTarget", branchTarget, addR);
        if (mo) begin
          chk("dmem_we", 32'(dmem_we), 32'(cb[2]));
          chk("dmem_addr", dmem_addr, ula);
          chk("dmem_wdata", dmem_wdata, rd2);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset       = 1'b0;
    controlBits = 5'b0;
    addResult   = '0;
    zero        = 1'b0;
    ulaResult   = '0;
    rData2      = '0;
    writeReg    = '0;
    dmem_rdata  = '0;
    dmem_ack    = 1'b0;
    #3;
    chk("rst_wb", 32'(wbControl), 32'd0);
    chk("rst_md", memDataW, 32'd0);
    chk("rst_alu", aluResultW, 32'd0);
    chk("rst_wr", 32'(writeRegW), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // non-memory op
    issue(5'b00010, 32'h0, 1'b0, 32'h1234, 32'h0, 5'd7,
          0, 32'h0, 1'b0, '{2'b10, 32'h0, 32'h1234, 5'd7});
    // load, ack after three wait cycles
    issue(5'b01011, 32'h0, 1'b0, 32'h100, 32'h0, 5'd9,
          3, 32'hCAFEF00D, 1'b0,
          '{2'b11, 32'hCAFEF00D, 32'h100, 5'd9});
    // store acked in the same cycle
    issue(5'b00100, 32'h0, 1'b0, 32'h200, 32'hDEADBEEF, 5'd3,
          0, 32'h0, 1'b0,
          '{2'b00, 32'hCAFEF00D, 32'h200, 5'd3});
    // back-to-back loads
    issue(5'b01011, 32'h0, 1'b0, 32'h300, 32'h0, 5'd4,
          0, 32'h11112222, 1'b0,
          '{2'b11, 32'h11112222, 32'h300, 5'd4});
    issue(5'b01011, 32'h0, 1'b0, 32'h304, 32'h0, 5'd5,
          1, 32'h33334444, 1'b0,
          '{2'b11, 32'h33334444, 32'h304, 5'd5});
    // read+write together is a write: load data ignored
    issue(5'b01110, 32'h0, 1'b0, 32'h44, 32'hAAAA, 5'd6,
          0, 32'h55, 1'b0,
          '{2'b10, 32'h33334444, 32'h44, 5'd6});
    // branches
    issue(5'b10000, 32'h400, 1'b1, 32'h0, 32'h0, 5'd0,
          0, 32'h0, 1'b1,
          '{2'b00, 32'h33334444, 32'h0, 5'd0});
    issue(5'b10000, 32'h400, 1'b0, 32'h8, 32'h0, 5'd1,
          0, 32'h0, 1'b0,
          '{2'b00, 32'h33334444, 32'h8, 5'd1});
    idle();

    // reset two cycles into a pending load
    @(negedge clk);
    controlBits = 5'b01011;
    ulaResult   = 32'h500;
    writeReg    = 5'd8;
    dmem_ack    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_wb", 32'(wbControl), 32'd0);
    chk("mid_rst_md", memDataW, 32'd0);
    chk("mid_rst_alu", aluResultW, 32'd0);
    chk("mid_rst_wr", 32'(writeRegW), 32'd0);
    @(negedge clk);
    controlBits = 5'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("post_rst_stall", 32'(stall), 32'd0);
    chk("post_rst_req", 32'(dmem_req), 32'd0);

    issue(5'b00011, 32'h0, 1'b0, 32'h77, 32'h0, 5'd2,
          0, 32'h0, 1'b0, '{2'b11, 32'h0, 32'h77, 5'd2});
    issue(5'b01011, 32'h0, 1'b0, 32'h80, 32'h0, 5'd12,
          1, 32'hBEEF0001, 1'b0,
          '{2'b11, 32'hBEEF0001, 32'h80, 5'd12});
    idle();

`ifdef MEM_TIMEOUT_EN
    // load that is never acknowledged
    @(negedge clk);
    controlBits = 5'b01011;
    ulaResult   = 32'h600;
    writeReg    = 5'd10;
    dmem_rdata  = 32'h99999999;
    dmem_ack    = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall) break;
      cnt++;
      @(negedge clk);
    end
    chk("tmo_stall_cycles", 32'(cnt), 32'd16);
    @(posedge clk);
    #2;
    chk("tmo_err", 32'(mem_err), 32'd1);
    chk("tmo_wb", 32'(wbControl), 32'd0);
    chk("tmo_md", memDataW, 32'hBEEF0001);
    idle();
    repeat (3) @(negedge clk);
    chk("tmo_err_sticky", 32'(mem_err), 32'd1);
`else
    cnt = 0;
    chk("err_tied", 32'(mem_err), 32'(cnt));
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule
